mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between the CPU memory path (MAR/MDR, driven by
//  Control during fetch and ld/st states) and the program-loader/IO port. Two-requester
//  req/ack arbiter with round-robin fairness, read-latency sequencing and a one-cycle
//  write strobe. Sits between the datapath memory interface and the RAM macro.
// PARAMETERS
//  AW      9  RAM word-address width
//  DW      32 data width
//  RD_LAT  1  RAM read latency in cycles, legal 1..4
// PORTS
//  clk         in  1   system clock, all state on posedge
//  reset_n     in  1   asynchronous, active-low reset
//  cpu_req     in  1   CPU access request, held until cpu_ack
//  cpu_wr      in  1   1=write, 0=read; stable while cpu_req
//  cpu_addr    in  AW  CPU word address (MAR)
//  cpu_wdata   in  DW  CPU write data (MDR)
//  cpu_ack     out 1   one-cycle completion pulse
//  cpu_rdata   out DW  read data, valid when cpu_ack && !cpu_wr
//  ldr_req     in  1   loader/IO request, same rules as cpu_req
//  ldr_wr      in  1   loader write enable
//  ldr_addr    in  AW  loader address
//  ldr_wdata   in  DW  loader write data
//  ldr_ack     out 1   one-cycle completion pulse
//  ldr_rdata   out DW  read data, valid when ldr_ack && !ldr_wr
//  ram_addr    out AW  RAM address
//  ram_wdata   out DW  RAM write data
//  ram_we      out 1   RAM write strobe
//  ram_rdata   in  DW  RAM read data, RD_LAT cycles after address sampled
//  grant_cpu   out 1   1 while CPU owns the RAM (GRANT/WAIT)
//  busy        out 1   1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE, ram_we=0, ram_addr=0, ram_wdata=0, acks=0, rdata=0, grant_cpu=0,
//    busy=0, last_grant=LDR (CPU wins the first contested cycle). Reset mid-access aborts it:
//    no ack, ram_we drops immediately.
//  - States: IDLE -> GRANT -> (write) IDLE | (read) WAIT -> IDLE.
//  - IDLE: sample reqs at posedge. One requesting -> grant it. Both -> grant the one that
//    is NOT last_grant; update last_grant on every grant.
//  - GRANT (1 cycle): ram_addr/ram_wdata registered from winner; write: ram_we=1 and
//    winner ack=1 in this same cycle, next state IDLE. Read: ram_we=0, next WAIT.
//  - WAIT: counter runs RD_LAT cycles; in last WAIT cycle winner ack=1 and winner rdata
//    = ram_rdata (registered, held until next read ack for that port); next IDLE.
//  - Latency from req seen in IDLE (cycle N): write ack at N+1, read ack at N+1+RD_LAT.
//  - Mandatory IDLE cycle between accesses: back-to-back from one requester = 2 cycles/write.
//  - Requester inputs captured at grant; changes after grant are ignored. req dropped before
//    ack: access still completes and ack still pulses (violation, not an error).
//  - req still high in the cycle after ack = new request.
//  - Never both acks in one cycle; ram_we only in GRANT of a write.
// CONFIGURATION
//  ARB_CPU_PRIORITY_EN defined: fixed priority, CPU always wins contested IDLE cycles;
//    last_grant unused; loader can starve while CPU requests continuously.
//  Not defined: round-robin as above; neither requester waits more than one access.
// TESTING
//  1 reset_n=0 mid-read (WAIT) -> all outputs 0 in same cycle, no ack after release.
//  2 CPU write addr=0x010 data=0xDEADBEEF -> ram_we=1 one cycle N+1, cpu_ack same cycle.
//  3 CPU read 0x010, RD_LAT=1 -> cpu_ack at N+2, cpu_rdata=0xDEADBEEF; repeat RD_LAT=3 -> N+4.
//  4 cpu_req and ldr_req held high from reset -> grants CPU,LDR,CPU,LDR; no double ack.
//  5 Same as 4 with ARB_CPU_PRIORITY_EN -> CPU granted every access, ldr_ack never.
//  6 Loader writes 0x1FF=0x12345678 then CPU reads 0x1FF -> cpu_rdata=0x12345678; addr wrap ok.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port data RAM between the CPU memory path (MAR/MDR) and
//   the program-loader/IO port. Two-requester req/ack arbiter, one access at a
//   time: IDLE -> GRANT -> IDLE (write) or IDLE -> GRANT -> WAIT -> IDLE (read).
//
// Parameters
//   AW      RAM word-address width
//   DW      data width
//   RD_LAT  RAM read latency in cycles (1..4)
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   cpu_req/wr/addr/wdata        CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata           CPU one-cycle completion pulse, read data
//   ldr_req/wr/addr/wdata        loader request, same handshake
//   ldr_ack, ldr_rdata           loader completion pulse, read data
//   ram_addr/wdata/we, ram_rdata RAM macro interface
//   grant_cpu                    CPU owns the RAM (GRANT/WAIT)
//   busy                         any state other than IDLE
//
// Configuration
//   ARB_CPU_PRIORITY_EN  defined: CPU always wins contested IDLE cycles.
//                        undefined: round-robin on contested IDLE cycles.
module mem_port_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_wr,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          grant_cpu,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

  // WAIT counter loads RD_LAT-1 and the ack is raised entering the last WAIT cycle
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t        state;
  logic          cur_wr;
  logic [1:0]    cnt;
  logic [DW-1:0] cpu_rdata_q, ldr_rdata_q;

  logic          pick_cpu, pick_wr;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;
  logic          rd_ack_cyc;

`ifdef ARB_CPU_PRIORITY_EN
  always_comb pick_cpu = cpu_req;
`else
  // 1 = last grant went to the CPU; reset value 0 lets the CPU win first
  logic last_cpu;
  always_comb pick_cpu = cpu_req && (!ldr_req || !last_cpu);
`endif

  always_comb begin
    pick_wr    = pick_cpu ? cpu_wr    : ldr_wr;
    pick_addr  = pick_cpu ? cpu_addr  : ldr_addr;
    pick_wdata = pick_cpu ? cpu_wdata : ldr_wdata;
  end

  // The read ack is registered but the RAM data only lands during that same
  // cycle, so the ack cycle passes ram_rdata through and the holding register
  // takes over afterwards.
  assign rd_ack_cyc = (state == WAIT);
  assign cpu_rdata  = (cpu_ack && rd_ack_cyc) ? ram_rdata : cpu_rdata_q;
  assign ldr_rdata  = (ldr_ack && rd_ack_cyc) ? ram_rdata : ldr_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_wr      <= 1'b0;
      cnt         <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      grant_cpu   <= 1'b0;
      busy        <= 1'b0;
`ifndef ARB_CPU_PRIORITY_EN
      last_cpu    <= 1'b0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      ram_we  <= 1'b0;
      if (cpu_ack && rd_ack_cyc) cpu_rdata_q <= ram_rdata;
      if (ldr_ack && rd_ack_cyc) ldr_rdata_q <= ram_rdata;
      case (state)
        IDLE: if (cpu_req || ldr_req) begin
          state     <= GRANT;
          busy      <= 1'b1;
          grant_cpu <= pick_cpu;
`ifndef ARB_CPU_PRIORITY_EN
          last_cpu  <= pick_cpu;
`endif
          cur_wr    <= pick_wr;
          ram_addr  <= pick_addr;
          ram_wdata <= pick_wdata;
          // write completes in GRANT: strobe and ack together
          ram_we    <= pick_wr;
          cpu_ack   <= pick_wr &&  pick_cpu;
          ldr_ack   <= pick_wr && !pick_cpu;
        end
        GRANT: if (cur_wr) begin
          state     <= IDLE;
          busy      <= 1'b0;
          grant_cpu <= 1'b0;
        end else begin
          state   <= WAIT;
          cnt     <= CNT_INIT;
          cpu_ack <= (RD_LAT == 1) &&  grant_cpu;
          ldr_ack <= (RD_LAT == 1) && !grant_cpu;
        end
        WAIT: if (cnt == 2'd0) begin
          state     <= IDLE;
          busy      <= 1'b0;
          grant_cpu <= 1'b0;
        end else begin
          cnt     <= cnt - 2'd1;
          cpu_ack <= (cnt == 2'd1) &&  grant_cpu;
          ldr_ack <= (cnt == 2'd1) && !grant_cpu;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with
// a behavioural RAM. Expected acks (port, cycle, read data) go into a per-DUT
// scoreboard queue when a request is raised and are popped on every ack.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n     [2];
  logic        cpu_req   [2];
  logic        cpu_wr    [2];
  logic [8:0]  cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_ack   [2];
  logic [31:0] cpu_rdata [2];
  logic        ldr_req   [2];
  logic        ldr_wr    [2];
  logic [8:0]  ldr_addr  [2];
  logic [31:0] ldr_wdata [2];
  logic        ldr_ack   [2];
  logic [31:0] ldr_rdata [2];
  logic [8:0]  ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic        ram_we    [2];
  logic [31:0] ram_rdata [2];
  logic        grant_cpu [2];
  logic        busy      [2];

  mem_port_arbiter #(.AW(9), .DW(32), .RD_LAT(1)) u0 (
    .clk(clk), .reset_n(rst_n[0]),
    .cpu_req(cpu_req[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .ldr_req(ldr_req[0]), .ldr_wr(ldr_wr[0]), .ldr_addr(ldr_addr[0]), .ldr_wdata(ldr_wdata[0]),
    .ldr_ack(ldr_ack[0]), .ldr_rdata(ldr_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]), .ram_rdata(ram_rdata[0]),
    .grant_cpu(grant_cpu[0]), .busy(busy[0]));

  mem_port_arbiter #(.AW(9), .DW(32), .RD_LAT(3)) u1 (
    .clk(clk), .reset_n(rst_n[1]),
    .cpu_req(cpu_req[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .ldr_req(ldr_req[1]), .ldr_wr(ldr_wr[1]), .ldr_addr(ldr_addr[1]), .ldr_wdata(ldr_wdata[1]),
    .ldr_ack(ldr_ack[1]), .ldr_rdata(ldr_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]), .ram_rdata(ram_rdata[1]),
    .grant_cpu(grant_cpu[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: address sampled at posedge, data out RD_LAT cycles later
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [31:0] p0;
  logic [31:0] p1 [3];
  always @(posedge clk) begin
    if (ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    p0 <= mem0[ram_addr[0]];
    if (ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    p1[0] <= mem1[ram_addr[1]];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign ram_rdata[0] = p0;
  assign ram_rdata[1] = p1[2];

  typedef struct {
    bit          port;   // 1 = CPU, 0 = loader
    bit          wr;
    logic [31:0] rdata;
    int          due;    // absolute cycle of the expected ack
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  int errors = 0;
  int checks = 0;
  int stray  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Ack monitor / scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d]) begin
        checks++;
        if (!(cpu_ack[d] || ldr_ack[d])) begin
          errors++;
          $display("FAIL we_without_ack dut=%0d cyc=%0d got ram_we=1 want 0", d, cyc);
        end
      end
      if (cpu_ack[d] || ldr_ack[d]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        checks++;
        if (cpu_ack[d] && ldr_ack[d]) begin
          errors++;
          $display("FAIL double_ack dut=%0d cyc=%0d got both acks want one", d, cyc);
        end else if (!have) begin
          errors++;
          stray++;
          $display("FAIL stray_ack dut=%0d cyc=%0d got ack want none", d, cyc);
        end else begin
          if (cpu_ack[d] != e.port)
            begin errors++; $display("FAIL ack_port dut=%0d cyc=%0d got cpu=%0d want cpu=%0d", d, cyc, cpu_ack[d], e.port); end
          if (cyc != e.due)
            begin errors++; $display("FAIL ack_cycle dut=%0d got=%0d want=%0d", d, cyc, e.due); end
          if (e.wr && !ram_we[d])
            begin errors++; $display("FAIL wr_strobe dut=%0d cyc=%0d got ram_we=0 want 1", d, cyc); end
          if (!e.wr) begin
            logic [31:0] rd;
            rd = e.port ? cpu_rdata[d] : ldr_rdata[d];
            if (rd !== e.rdata)
              begin errors++; $display("FAIL rdata dut=%0d got=%h want=%h", d, rd, e.rdata); end
          end
        end
      end
    end
  end

  typedef struct {
    bit          d;
    bit          port;
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  task automatic push(input bit d, input bit port, input bit wr, input logic [31:0] rd, input int due);
    exp_t e;
    e.port = port; e.wr = wr; e.rdata = rd; e.due = due;
    if (d) sb1.push_back(e); else sb0.push_back(e);
  endtask

  // One access: raise req in an IDLE cycle, hold until ack, then drop
  task automatic access(input vec_t v);
    int lat;
    bit seen;
    @(negedge clk);
    lat = v.wr ? 1 : (1 + (v.d ? 3 : 1));
    if (v.port) begin
      cpu_req[v.d] = 1'b1; cpu_wr[v.d] = v.wr; cpu_addr[v.d] = v.addr; cpu_wdata[v.d] = v.wdata;
    end else begin
      ldr_req[v.d] = 1'b1; ldr_wr[v.d] = v.wr; ldr_addr[v.d] = v.addr; ldr_wdata[v.d] = v.wdata;
    end
    push(v.d, v.port, v.wr, v.exp, cyc + lat);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = v.port ? cpu_ack[v.d] : ldr_ack[v.d];
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL ack_timeout dut=%0d addr=%h got no ack want ack", v.d, v.addr);
    end
    cpu_req[v.d] = 1'b0;
    ldr_req[v.d] = 1'b0;
  endtask

  task automatic drain(input bit d);
    int n;
    n = 0;
    while ((d ? sb1.size() : sb0.size()) > 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((d ? sb1.size() : sb0.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout dut=%0d got pending=%0d want 0", d, d ? sb1.size() : sb0.size());
    end
  endtask

  initial begin
    int c;
    //            d     port  wr    addr     wdata          expected read
    vt[0] = '{1'b0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
    vt[4] = '{1'b0, 1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
    vt[5] = '{1'b0, 1'b1, 1'b1, 9'h000, 32'h00000001, 32'h0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        32'h00000001};
    vt[7] = '{1'b1, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
    vt[9] = '{1'b1, 1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'h0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      cpu_req[d] = 1'b0; cpu_wr[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      ldr_req[d] = 1'b0; ldr_wr[d] = 1'b0; ldr_addr[d] = '0; ldr_wdata[d] = '0;
    end
    // both requesters writing and held high from reset
    cpu_req[0] = 1'b1; cpu_wr[0] = 1'b1; cpu_addr[0] = 9'h100; cpu_wdata[0] = 32'hC0C0C0C0;
    ldr_req[0] = 1'b1; ldr_wr[0] = 1'b1; ldr_addr[0] = 9'h101; ldr_wdata[0] = 32'h1D1D1D1D;
    repeat (3) @(negedge clk);

    chk("rst_cpu_ack",   32'(cpu_ack[0]),   32'h0);
    chk("rst_ldr_ack",   32'(ldr_ack[0]),   32'h0);
    chk("rst_ram_we",    32'(ram_we[0]),    32'h0);
    chk("rst_ram_addr",  32'(ram_addr[0]),  32'h0);
    chk("rst_ram_wdata", ram_wdata[0],      32'h0);
    chk("rst_cpu_rdata", cpu_rdata[0],      32'h0);
    chk("rst_ldr_rdata", ldr_rdata[0],      32'h0);
    chk("rst_grant_cpu", 32'(grant_cpu[0]), 32'h0);
    chk("rst_busy",      32'(busy[0]),      32'h0);

    // contention: CPU wins first, then alternation (or CPU every time)
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    c = cyc;
`ifdef ARB_CPU_PRIORITY_EN
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, 1'b1, 32'h0, c + 1 + 2 * k);
`else
    for (int k = 0; k < 4; k++) push(1'b0, (k % 2) == 0, 1'b1, 32'h0, c + 1 + 2 * k);
`endif
    repeat (7) @(negedge clk);
    cpu_req[0] = 1'b0;
    ldr_req[0] = 1'b0;
    drain(1'b0);

    // table-driven single accesses on both latencies
    for (int i = 0; i < 10; i++) access(vt[i]);
    drain(1'b0);
    drain(1'b1);

    // read data held until the next read ack of that port
    chk("cpu_rdata_hold", cpu_rdata[0], 32'h12345678);
    chk("ldr_rdata_hold", ldr_rdata[0], 32'h00000001);

    // inputs changed and req dropped after grant: access still completes
    @(negedge clk);
    cpu_req[1] = 1'b1; cpu_wr[1] = 1'b0; cpu_addr[1] = 9'h010;
    push(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, cyc + 4);
    @(negedge clk);
    cpu_req[1] = 1'b0; cpu_addr[1] = 9'h1FF; cpu_wr[1] = 1'b1;
    drain(1'b1);

    // reset in the middle of a RD_LAT=3 read
    @(negedge clk);
    cpu_req[1] = 1'b1; cpu_wr[1] = 1'b0; cpu_addr[1] = 9'h1FF;
    @(negedge clk);  // GRANT
    cpu_req[1] = 1'b0;
    @(negedge clk);  // WAIT 1
    @(negedge clk);  // WAIT 2
    chk("mid_read_busy", 32'(busy[1]), 32'h1);
    rst_n[1] = 1'b0;
    #1;
    chk("abort_busy",      32'(busy[1]),      32'h0);
    chk("abort_grant_cpu", 32'(grant_cpu[1]), 32'h0);
    chk("abort_ram_addr",  32'(ram_addr[1]),  32'h0);
    chk("abort_ram_wdata", ram_wdata[1],      32'h0);
    chk("abort_cpu_rdata", cpu_rdata[1],      32'h0);
    chk("abort_cpu_ack",   32'(cpu_ack[1]),   32'h0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_ack_after_abort", 32'(stray), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
